// File: rtl/stage2_packet_tx_module.sv
// Stage-2 transmit serialiser: header, up to three messages, then running byte-sum trailer.
// Emits one byte per transfer on a registered valid/ready byte stream.
module stage2_packet_tx_module #(
   parameter int MSG_BITS = 280,
   parameter int CHK_BITS = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [15:0]         block_size_data,
   input  logic [31:0]         seq_number_data,
   input  logic [7:0]          message_number_data,
   input  logic [63:0]         time_message_data,
   input  logic [MSG_BITS-1:0] message_1,
   input  logic [MSG_BITS-1:0] message_2,
   input  logic [MSG_BITS-1:0] message_3,
   output logic [7:0]          out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last,
   output logic                busy
);

   localparam int MSG_BYTES = MSG_BITS / 8;
   localparam int CHK_BYTES = CHK_BITS / 8;
   localparam int HDR_BYTES = 15;
   localparam int CNT_W     = 16;
   localparam int MSGS_W    = 3 * MSG_BITS;

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_MSG, S_CHK} state_t;

   state_t                r_state;
   logic [111:0]          r_hdr;
   logic [MSGS_W-1:0]     r_msg;
   logic [CHK_BITS-1:0]   r_acc;
   logic [CHK_BITS-1:0]   r_chk;
   logic [CNT_W-1:0]      r_cnt;
   logic [1:0]            r_num;
   logic [1:0]            r_msg_left;

   logic                  w_xfer;
   logic [CHK_BITS-1:0]   w_acc_next;
   logic [1:0]            w_num;

   assign w_xfer     = out_valid && out_ready;
   assign w_acc_next = r_acc + CHK_BITS'(out_data);
   assign w_num      = (message_number_data > 8'd3) ? 2'd3 : message_number_data[1:0];

   // out_data always holds the byte on the wire; the shift registers hold the bytes still to come.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_hdr      <= '0;
         r_msg      <= '0;
         r_acc      <= '0;
         r_chk      <= '0;
         r_cnt      <= '0;
         r_num      <= '0;
         r_msg_left <= '0;
         in_ready   <= 1'b1;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  r_hdr     <= {block_size_data[7:0], seq_number_data, 6'b0, w_num, time_message_data};
                  r_msg     <= {message_1, message_2, message_3};
                  r_num     <= w_num;
                  r_acc     <= '0;
                  r_cnt     <= '0;
                  out_data  <= block_size_data[15:8];
                  out_valid <= 1'b1;
                  out_last  <= 1'b0;
                  busy      <= 1'b1;
                  in_ready  <= 1'b0;
                  r_state   <= S_HDR;
               end
            end

            S_HDR: begin
               if (w_xfer) begin
                  r_acc <= w_acc_next;
                  if (r_cnt == CNT_W'(HDR_BYTES - 1)) begin
                     r_cnt <= '0;
                     if (r_num != 2'd0) begin
                        out_data   <= r_msg[MSGS_W-1 -: 8];
                        r_msg      <= r_msg << 8;
                        r_msg_left <= r_num;
                        r_state    <= S_MSG;
                     end else begin
                        out_data <= w_acc_next[CHK_BITS-1 -: 8];
                        r_chk    <= w_acc_next << 8;
                        out_last <= (CHK_BYTES == 1);
                        r_state  <= S_CHK;
                     end
                  end else begin
                     r_cnt    <= r_cnt + 1'b1;
                     out_data <= r_hdr[111:104];
                     r_hdr    <= r_hdr << 8;
                  end
               end
            end

            S_MSG: begin
               if (w_xfer) begin
                  r_acc <= w_acc_next;
                  if (r_cnt == CNT_W'(MSG_BYTES - 1) && r_msg_left == 2'd1) begin
                     r_cnt    <= '0;
                     out_data <= w_acc_next[CHK_BITS-1 -: 8];
                     r_chk    <= w_acc_next << 8;
                     out_last <= (CHK_BYTES == 1);
                     r_state  <= S_CHK;
                  end else begin
                     if (r_cnt == CNT_W'(MSG_BYTES - 1)) begin
                        r_cnt      <= '0;
                        r_msg_left <= r_msg_left - 1'b1;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                     out_data <= r_msg[MSGS_W-1 -: 8];
                     r_msg    <= r_msg << 8;
                  end
               end
            end

            S_CHK: begin
               if (w_xfer) begin
                  if (r_cnt == CNT_W'(CHK_BYTES - 1)) begin
                     r_cnt     <= '0;
                     out_data  <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     in_ready  <= 1'b1;
                     r_state   <= S_IDLE;
                  end else begin
                     r_cnt    <= r_cnt + 1'b1;
                     out_data <= r_chk[CHK_BITS-1 -: 8];
                     r_chk    <= r_chk << 8;
                     out_last <= (r_cnt == CNT_W'(CHK_BYTES - 2));
                  end
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stage2_packet_tx_module.sv
// Scoreboard bench for stage2_packet_tx_module: stimulus pushes expected bytes, a monitor pops and compares.
module tb_stage2_packet_tx_module;

   localparam int MSG_BITS = 280;
   localparam int MB       = MSG_BITS / 8;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [15:0]         block_size_data = '0;
   logic [31:0]         seq_number_data = '0;
   logic [7:0]          message_number_data = '0;
   logic [63:0]         time_message_data = '0;
   logic [MSG_BITS-1:0] message_1 = '0;
   logic [MSG_BITS-1:0] message_2 = '0;
   logic [MSG_BITS-1:0] message_3 = '0;
   logic [7:0]          out_data;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic                out_last;
   logic                busy;

   stage2_packet_tx_module #(.MSG_BITS(MSG_BITS), .CHK_BITS(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .block_size_data(block_size_data), .seq_number_data(seq_number_data),
      .message_number_data(message_number_data), .time_message_data(time_message_data),
      .message_1(message_1), .message_2(message_2), .message_3(message_3),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [8:0]  exp_q[$];
   int          mon_cnt = 0;
   int          frames_done = 0;
   int          last_len = 0;
   logic [31:0] last_chk = '0;
   logic [31:0] trl = '0;
   logic [7:0]  cap_count = '0;
   bit          bp_en = 1'b0;

   logic        p_valid = 1'b0;
   logic        p_ready = 1'b1;
   logic        p_last = 1'b0;
   logic [7:0]  p_data = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference serialisation: header, clamped messages, byte-sum trailer.
   task automatic push_model(input logic [15:0] bs, input logic [31:0] seq, input logic [7:0] num,
                             input logic [63:0] tm, input logic [MSG_BITS-1:0] m1,
                             input logic [MSG_BITS-1:0] m2, input logic [MSG_BITS-1:0] m3);
      logic [7:0]          b[$];
      logic [7:0]          n;
      logic [31:0]         s;
      logic [MSG_BITS-1:0] m;
      n = (num > 8'd3) ? 8'd3 : num;
      b.push_back(bs[15:8]);
      b.push_back(bs[7:0]);
      for (int i = 0; i < 4; i++) b.push_back(seq[31-8*i -: 8]);
      b.push_back(n);
      for (int i = 0; i < 8; i++) b.push_back(tm[63-8*i -: 8]);
      for (int k = 0; k < int'(n); k++) begin
         m = (k == 0) ? m1 : (k == 1) ? m2 : m3;
         for (int j = 0; j < MB; j++) b.push_back(m[MSG_BITS-1-8*j -: 8]);
      end
      s = '0;
      foreach (b[i]) begin
         s = s + {24'd0, b[i]};
         exp_q.push_back({1'b0, b[i]});
      end
      for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), s[31-8*i -: 8]});
   endtask

   always @(posedge clk) begin
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      logic [8:0] e;
      if (rst) begin
         p_valid = 1'b0;
      end else begin
         if (p_valid && !p_ready) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(out_data), 64'(p_data));
            check("hold_last", 64'(out_last), 64'(p_last));
         end
         if (out_valid) begin
            check("in_ready_busy", 64'(in_ready), 64'd0);
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_byte: got %0h expected none", out_data);
               end else begin
                  e = exp_q.pop_front();
                  check("byte", 64'(out_data), 64'(e[7:0]));
                  check("last", 64'(out_last), 64'(e[8]));
               end
               if (mon_cnt == 6) cap_count = out_data;
               trl = {trl[23:0], out_data};
               mon_cnt++;
               if (out_last) begin
                  last_len = mon_cnt;
                  last_chk = trl;
                  mon_cnt = 0;
                  frames_done++;
               end
            end
         end
         p_valid = out_valid;
         p_ready = out_ready;
         p_data  = out_data;
         p_last  = out_last;
      end
   end

   task automatic send(input logic [15:0] bs, input logic [31:0] seq, input logic [7:0] num,
                       input logic [63:0] tm, input logic [MSG_BITS-1:0] m1,
                       input logic [MSG_BITS-1:0] m2, input logic [MSG_BITS-1:0] m3);
      bit seen;
      push_model(bs, seq, num, tm, m1, m2, m3);
      @(posedge clk); #1;
      block_size_data = bs; seq_number_data = seq; message_number_data = num;
      time_message_data = tm; message_1 = m1; message_2 = m2; message_3 = m3;
      in_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin seen = 1'b1; break; end
      end
      check("accept_ready", 64'(seen), 64'd1);
      check("pre_accept_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      block_size_data = 16'($urandom); seq_number_data = $urandom;
      message_number_data = 8'($urandom); time_message_data = {$urandom, $urandom};
      @(negedge clk);
      check("first_valid", 64'(out_valid), 64'd1);
      check("busy_set", 64'(busy), 64'd1);
   endtask

   task automatic wait_frame(input int len, input logic [31:0] chk, input logic [7:0] cnt);
      int  start;
      bit  done;
      start = frames_done;
      done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         if (frames_done != start) begin done = 1'b1; break; end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL frame_timeout: got no out_last expected frame of %0d bytes", len);
         exp_q.delete();
      end else begin
         check("frame_len", 64'(last_len), 64'(len));
         check("trailer", 64'(last_chk), 64'(chk));
         check("count_byte", 64'(cap_count), 64'(cnt));
         check("queue_empty", 64'(exp_q.size()), 64'd0);
         @(negedge clk);
         check("end_valid", 64'(out_valid), 64'd0);
         check("end_in_ready", 64'(in_ready), 64'd1);
         check("end_busy", 64'(busy), 64'd0);
      end
   endtask

   initial begin
      bit reached;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      // header only: 1+2+1+2+3+4 = 0x0D
      send(16'h0102, 32'h01020304, 8'd0, 64'd0, '0, '0, '0);
      wait_frame(19, 32'h0000000D, 8'h00);

      send(16'h0000, 32'h0, 8'd1, 64'd0, '0, '0, '0);
      wait_frame(54, 32'h00000001, 8'h01);

      // 119 bytes of FF plus count byte 3
      send(16'hFFFF, 32'hFFFFFFFF, 8'd3, 64'hFFFFFFFF_FFFFFFFF, '1, '1, '1);
      wait_frame(124, 32'h0000768C, 8'h03);

      bp_en = 1'b1;
      send(16'hFFFF, 32'hFFFFFFFF, 8'd3, 64'hFFFFFFFF_FFFFFFFF, '1, '1, '1);
      wait_frame(124, 32'h0000768C, 8'h03);
      bp_en = 1'b0;

      // clamp 7 -> 3: 1+2+1+2+3+4+3 = 0x10
      send(16'h0102, 32'h01020304, 8'h07, 64'd0, '0, '0, '0);
      wait_frame(124, 32'h00000010, 8'h03);

      send(16'h1234, 32'hA5A5A5A5, 8'd2, 64'h0011223344556677, {35{8'h5A}}, {35{8'hC3}}, '0);
      reached = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         if (mon_cnt >= 40) begin reached = 1'b1; break; end
      end
      check("reached_byte40", 64'(reached), 64'd1);
      #1 rst = 1'b1;
      exp_q.delete();
      mon_cnt = 0;
      @(negedge clk);
      check("abort_valid", 64'(out_valid), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      check("abort_last", 64'(out_last), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_valid", 64'(out_valid), 64'd0);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      send(16'h0000, 32'h0, 8'd0, 64'd0, '0, '0, '0);
      wait_frame(19, 32'h00000000, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
